spi_master_phy: RTL

Parametrised SPI master PHY for the SD host path. It takes bytes (or wider words) from a small transmit FIFO and shifts them out in any of the four CPOL/CPHA modes, MSB- or LSB-first. Each word received on MISO is returned as a one-cycle valid pulse. It also drives multiple chip selects, with optional CS hold across back-to-back words. It sits between the SD controller's micro-sequencer and the board SPI pins.

---
 rtl/spi_master_phy.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/spi_master_phy.sv
// rtl/spi_master_phy.sv - SPI master PHY: TX FIFO, CPOL/CPHA modes, bit order, multi-CS with hold.
// Optional internal MOSI->sampler loopback when SPI_LOOPBACK_EN is defined.
module spi_master_phy #(
    parameter int DATA_W  = 8,
    parameter int DIV_W   = 8,
    parameter int CS_NUM  = 1,
    parameter int FIFO_AW = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [DIV_W-1:0]   div,
    input  logic               cpol,
    input  logic               cpha,
    input  logic               lsb_first,
    input  logic [CS_NUM-1:0]  cs_mask,
    input  logic               cs_hold,
    input  logic               wr,
    input  logic [DATA_W-1:0]  wr_data,
    output logic               wr_ready,
    output logic [FIFO_AW:0]   tx_level,
    output logic               rd,
    output logic [DATA_W-1:0]  rd_data,
    output logic               busy,
    output logic               spi_clk,
    output logic               spi_mosi,
    input  logic               spi_miso,
    output logic [CS_NUM-1:0]  spi_cs_n
`ifdef SPI_LOOPBACK_EN
    ,
    input  logic               loopback
`endif
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam int HP_W  = $clog2(2 * DATA_W + 1);
    localparam logic [HP_W-1:0] HP_LAST  = HP_W'(2 * DATA_W);
    localparam logic [HP_W-1:0] HP_FINAL_TRAIL = HP_W'(2 * DATA_W - 1);

    typedef enum logic [1:0] {IDLE, XFER, GUARD} state_t;

    state_t              state;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic [FIFO_AW-1:0]  wptr, rptr;
    logic [FIFO_AW:0]    count;
    logic                push, pop, fifo_empty;
    logic [DATA_W-1:0]   head;

    logic [DIV_W-1:0]    div_l, cnt;
    logic                cpha_l, lsb_l, cs_hold_l;
    logic [HP_W-1:0]     hp;
    logic [DATA_W-1:0]   tx_sr, rx_sr;
    logic                hp_end, sample_bit;
    logic                load_cpha;
    logic [DATA_W-1:0]   load_word;

    function automatic logic [DATA_W-1:0] rev(input logic [DATA_W-1:0] v);
        logic [DATA_W-1:0] r;
        for (int i = 0; i < DATA_W; i++) r[i] = v[DATA_W-1-i];
        return r;
    endfunction

    assign fifo_empty = (count == '0);
    assign wr_ready   = (count != (FIFO_AW+1)'(DEPTH));
    assign push       = wr && wr_ready;
    assign tx_level   = count;
    assign head       = mem[rptr];
    assign hp_end     = (cnt == div_l);
    assign busy       = (state != IDLE) || !fifo_empty;

    // Pop when leaving IDLE, or at frame end when CS hold chains the next word.
    assign pop = !fifo_empty &&
                 ((state == IDLE) ||
                  (state == XFER && hp_end && hp == HP_LAST && cs_hold_l));

`ifdef SPI_LOOPBACK_EN
    assign sample_bit = loopback ? spi_mosi : spi_miso;
`else
    assign sample_bit = spi_miso;
`endif

    // The shift register always moves MSB-first; LSB-first words are reversed on load/unload.
    assign load_cpha = (state == IDLE) ? cpha : cpha_l;
    assign load_word = ((state == IDLE) ? lsb_first : lsb_l) ? rev(head) : head;

    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + FIFO_AW'(1);
            if (pop)  rptr <= rptr + FIFO_AW'(1);
            count <= count + (FIFO_AW+1)'(push) - (FIFO_AW+1)'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            spi_clk   <= 1'b0;
            spi_cs_n  <= '1;
            spi_mosi  <= 1'b1;
            rd        <= 1'b0;
            rd_data   <= '0;
            cnt       <= '0;
            hp        <= '0;
            div_l     <= '0;
            cpha_l    <= 1'b0;
            lsb_l     <= 1'b0;
            cs_hold_l <= 1'b0;
            tx_sr     <= '0;
            rx_sr     <= '0;
        end else begin
            rd <= 1'b0;
            case (state)
                IDLE: begin
                    spi_clk  <= cpol;
                    spi_cs_n <= '1;
                    spi_mosi <= 1'b1;
                    cnt      <= '0;
                    hp       <= '0;
                    if (!fifo_empty) begin
                        div_l     <= div;
                        cpha_l    <= cpha;
                        lsb_l     <= lsb_first;
                        cs_hold_l <= cs_hold;
                        spi_cs_n  <= ~cs_mask;
                        if (!load_cpha) begin
                            spi_mosi <= load_word[DATA_W-1];
                            tx_sr    <= load_word << 1;
                        end else begin
                            tx_sr    <= load_word;
                        end
                        state <= XFER;
                    end
                end
                XFER: begin
                    if (!hp_end) begin
                        cnt <= cnt + DIV_W'(1);
                    end else begin
                        cnt <= '0;
                        if (hp != HP_LAST) begin
                            spi_clk <= ~spi_clk;
                            hp      <= hp + HP_W'(1);
                            if (hp[0] == 1'b0) begin
                                if (!cpha_l) begin
                                    rx_sr <= {rx_sr[DATA_W-2:0], sample_bit};
                                end else begin
                                    spi_mosi <= tx_sr[DATA_W-1];
                                    tx_sr    <= tx_sr << 1;
                                end
                            end else begin
                                if (cpha_l) begin
                                    rx_sr <= {rx_sr[DATA_W-2:0], sample_bit};
                                end else if (hp != HP_FINAL_TRAIL) begin
                                    spi_mosi <= tx_sr[DATA_W-1];
                                    tx_sr    <= tx_sr << 1;
                                end
                            end
                        end else begin
                            rd      <= 1'b1;
                            rd_data <= lsb_l ? rev(rx_sr) : rx_sr;
                            hp      <= '0;
                            if (cs_hold_l && !fifo_empty) begin
                                if (!load_cpha) begin
                                    spi_mosi <= load_word[DATA_W-1];
                                    tx_sr    <= load_word << 1;
                                end else begin
                                    tx_sr    <= load_word;
                                end
                            end else begin
                                spi_cs_n <= '1;
                                spi_mosi <= 1'b1;
                                state    <= GUARD;
                            end
                        end
                    end
                end
                GUARD: begin
                    // Minimum CS-high time of one half-period before the next frame.
                    if (!hp_end) begin
                        cnt <= cnt + DIV_W'(1);
                    end else begin
                        cnt   <= '0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
